pipeline_stall_controller: RTL
==============================

// Module: pipeline_stall_controller
// PURPOSE
//  Hazard sequencer for the 5-stage MIPS pipeline. Generates PC/IF_ID write enables, IF_ID flush and ID_EX bubble.
//  Detects load-use hazards and taken branches/jumps in EX. Tracks the multi-cycle mult/div HiLo latency and stalls
//  mfhi/mflo in ID until Hi/Lo are valid. Sits beside the Controller in ID; its outputs gate PC, IF_ID and ID_EX.
// PARAMETERS
//  MULDIV_LAT  4   cycles from mult/div in EX until HiLo is readable (legal range 1..15)
//  CNT_W       16  width of the performance counters (STALL_PERF_CNT_EN only)
// PORTS
//  Clk              in   1      pipeline clock, rising edge
//  Rst              in   1      asynchronous reset, active-low
//  id_rs            in   5      rs field of instruction in ID
//  id_rt            in   5      rt field of instruction in ID
//  id_uses_rt       in   1      ID instruction reads rt as a source
//  id_hilo_read     in   1      ID instruction is mfhi/mflo
//  ex_mem_read      in   1      EX instruction is a load
//  ex_rd            in   5      destination register of EX instruction (post RegDst mux)
//  ex_muldiv_start  in   1      EX instruction writes Hi/Lo (mult/multu/div/divu/madd/msub)
//  ex_branch_taken  in   1      branch/jump resolved taken in EX (PCSrc)
//  pc_write         out  1      1 = PC loads next address
//  if_id_write      out  1      1 = IF_ID register captures
//  if_id_flush      out  1      1 = IF_ID loads NOP (32'h0)
//  id_ex_bubble     out  1      1 = ID_EX control bits zeroed
//  hilo_busy        out  1      Hi/Lo result not yet valid
//  ctl_state        out  2      current FSM state (debug)
//  stall_cnt        out  CNT_W  stall cycles (STALL_PERF_CNT_EN only)
//  flush_cnt        out  CNT_W  flush events (STALL_PERF_CNT_EN only)
// BEHAVIOUR
//  - Registered: FSM state (RUN=2'd0, MD_STALL=2'd1) and md_cnt [3:0]. All outputs combinational from state, md_cnt, inputs.
//  - Reset (Rst=0, async): state=RUN, md_cnt=0, counters=0. With idle inputs: pc_write=1, if_id_write=1, flush=0, bubble=0, hilo_busy=0.
//  - hilo_busy = (md_cnt != 0).
//  - md_cnt: ex_muldiv_start loads MULDIV_LAT-1 (restarts if already busy). Otherwise decrements when nonzero; saturates at 0.
//  - load_use = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
//  - md_hz = id_hilo_read & (hilo_busy | ex_muldiv_start).
//  - Priority per cycle: branch > md_hz > load_use > none.
//    branch:    pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1; next RUN.
//    md_hz:     pc_write=0, if_id_write=0, id_ex_bubble=1; next MD_STALL.
//    load_use:  pc_write=0, if_id_write=0, id_ex_bubble=1; next RUN (exactly one bubble; WB forwarding resolves it).
//    none:      pc_write=1, if_id_write=1, flush=0, bubble=0; next RUN.
//  - MD_STALL: hold stall outputs while hilo_busy. Exit to RUN with normal outputs in the cycle md_cnt==0.
//    A branch in EX while in MD_STALL flushes and exits to RUN, because the stalled mfhi is discarded.
//  - The mult/div instruction has left ID. Its own progress through EX/MEM/WB is never stalled.
//  - Simultaneous ex_muldiv_start and load_use: load_use stall taken and md_cnt loaded in the same cycle.
//  - md_hz stall cycles = MULDIV_LAT when mfhi immediately follows mult in program order.
//  - Reset mid-stall: immediate return to RUN with md_cnt=0. Any in-flight HiLo result is treated as valid.
// CONFIGURATION
//  STALL_PERF_CNT_EN defined:
//    stall_cnt increments on every cycle with pc_write=0.
//    flush_cnt increments on every cycle with if_id_flush=1.
//    Both wrap modulo 2^CNT_W and are cleared only by reset.
//  Undefined: stall_cnt and flush_cnt ports are present and tied to 0. No counter registers are built.
// TESTING
//  1 Reset: Rst=0 mid-MD_STALL with md_cnt=3 -> immediately ctl_state=0, hilo_busy=0, pc_write=1, counters=0.
//  2 Load-use: ex_mem_read=1, ex_rd=8, id_rs=8 -> one cycle pc_write=0, id_ex_bubble=1; next cycle normal.
//    Repeat with ex_rd=0 -> no stall. Repeat with id_rt=8, id_uses_rt=0 -> no stall.
//  3 Mult->mfhi, MULDIV_LAT=4: start pulse then id_hilo_read=1 held -> pc_write=0 for exactly 4 cycles,
//    ctl_state=1 during stall, then resume.
//  4 Branch in MD_STALL: assert ex_branch_taken on cycle 2 of stall -> same cycle if_id_flush=1, pc_write=1; next ctl_state=0.
//  5 Priority: ex_branch_taken=1 with load_use true -> flush/bubble only, pc_write=1, no stall.
//  6 Perf (STALL_PERF_CNT_EN): after scenarios 2+3 -> stall_cnt=5. After one branch -> flush_cnt=1.
//    Preload counters to 2^CNT_W-1, add one stall cycle -> stall_cnt wraps to 0.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - hazard sequencer for the 5-stage MIPS pipeline
// Optional build macro: STALL_PERF_CNT_EN adds stall/flush performance counters.
module pipeline_stall_controller #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_hilo_read,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_muldiv_start,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             hilo_busy,
  output logic [1:0]       ctl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_STALL = 2'd1
  } state_t;

  // Value loaded when a mult/div enters EX; reaching zero means Hi/Lo is readable.
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] md_cnt;
  logic [3:0] md_cnt_nxt;

  logic load_use;
  logic md_hz;
  logic md_hold;

  assign hilo_busy = (md_cnt != 4'd0);
  assign ctl_state = state;

  // Hazard detection terms from the ID and EX stage fields.
  always_comb begin
    load_use = ex_mem_read & (ex_rd != 5'd0) &
               ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    md_hz    = id_hilo_read & (hilo_busy | ex_muldiv_start);
    // Once in MD_STALL the stall is held until Hi/Lo is valid.
    md_hold  = (state == MD_STALL) & hilo_busy;
  end

  // Prioritised output decode: branch > mfhi/mflo hazard > load-use > none.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_nxt    = RUN;
    if (ex_branch_taken) begin
      // Wrong-path instruction in IF_ID (including a stalled mfhi) is discarded.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (md_hz | md_hold) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      state_nxt    = MD_STALL;
    end else if (load_use) begin
      // Single bubble; WB forwarding covers the load result afterwards.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // HiLo latency counter: restart on every mult/div, otherwise count down to zero.
  always_comb begin
    md_cnt_nxt = md_cnt;
    if (ex_muldiv_start) begin
      md_cnt_nxt = MD_LOAD;
    end else if (md_cnt != 4'd0) begin
      md_cnt_nxt = md_cnt - 4'd1;
    end
  end

  // State and latency counter registers; reset treats any in-flight HiLo as valid.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Free-running event counters, wrapping naturally, cleared only by reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write) begin
        stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (if_id_flush) begin
        flush_q <= flush_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
